pll_reconfig_ctrl: RTL

//  Sequencer for the PLLA dynamic-reconfiguration (MD*) port. Accepts one divider-update request
//  (output-channel ODIV or feedback MDIV), then sets the address, writes, optionally reads back to

---
 rtl/pll_reconfig_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/pll_reconfig_ctrl.sv
// PLL dynamic-reconfiguration sequencer.
// Takes one divider-update request (ODIV channel or MDIV), drives the MD port
// through address/write/optional readback, pulses the PLL reset and waits for
// a stable lock before reporting completion with a status code.
module pll_reconfig_ctrl #(
    parameter int         N_CH        = 4,
    parameter logic [7:0] ODIV_BASE   = 8'h10,
    parameter logic [7:0] MDIV_ADDR   = 8'h08,
    parameter bit         VERIFY      = 1'b1,
    parameter int         RD_LAT      = 1,
    parameter int         RST_CYCLES  = 16,
    parameter int         LOCK_STABLE = 64,
    parameter int         LOCK_TMO    = 65535
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_ch,
    input  logic [7:0] req_div,
    output logic       done,
    output logic [1:0] status,
    output logic       busy,
    output logic       locked,
    output logic       pll_reset,
    input  logic       pll_lock,
    output logic [1:0] md_opc,
    output logic       md_ainc,
    output logic [7:0] md_wdi,
    input  logic [7:0] md_rdo
);
    localparam int TW = $clog2(LOCK_TMO + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int LW = $clog2(RD_LAT + 1);

    localparam logic [TW-1:0] TMO_TGT    = TW'(LOCK_TMO);
    localparam logic [SW-1:0] STABLE_TGT = SW'(LOCK_STABLE);
    localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);
    localparam logic [LW-1:0] RD_LAST    = LW'(RD_LAT - 1);
    localparam logic [2:0]    N_CH_L     = 3'(N_CH);
    localparam logic [2:0]    CH_MDIV    = 3'd7;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_ADDR = 2'b11;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_VFAIL  = 2'b01;
    localparam logic [1:0] ST_TMO    = 2'b10;
    localparam logic [1:0] ST_BADCH  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WRITE, S_VADDR, S_READ, S_RWAIT,
        S_CHECK, S_PRST, S_WAIT_LOCK, S_DONE
    } state_t;

    state_t        state_reg;
    logic [2:0]    ch_reg;
    logic [7:0]    div_reg;
    logic [7:0]    rd_data_reg;
    logic [RW-1:0] rst_cnt_reg;
    logic [LW-1:0] rd_cnt_reg;
    logic [SW-1:0] stable_cnt_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic          lock_meta_reg;

    logic          req_ch_ok;
    logic          ch_ok;
    logic [7:0]    req_addr;
    logic [7:0]    tgt_addr;
    logic [SW-1:0] stable_next;
    logic [TW-1:0] tmo_next;

    // Channel decode for the incoming request and for the latched one
    assign req_ch_ok   = (req_ch == CH_MDIV) || (req_ch < N_CH_L);
    assign ch_ok       = (ch_reg == CH_MDIV) || (ch_reg < N_CH_L);
    assign req_addr    = (req_ch == CH_MDIV) ? MDIV_ADDR : ODIV_BASE + {5'd0, req_ch};
    assign tgt_addr    = (ch_reg == CH_MDIV) ? MDIV_ADDR : ODIV_BASE + {5'd0, ch_reg};
    assign stable_next = locked ? stable_cnt_reg + 1'b1 : '0;
    assign tmo_next    = tmo_cnt_reg + 1'b1;

    // Only single-register accesses are issued
    assign md_ainc = 1'b0;

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_reg <= 1'b0;
            locked        <= 1'b0;
        end else begin
            lock_meta_reg <= pll_lock;
            locked        <= lock_meta_reg;
        end
    end

    // Reconfiguration sequencer with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            ch_reg         <= '0;
            div_reg        <= '0;
            rd_data_reg    <= '0;
            rst_cnt_reg    <= '0;
            rd_cnt_reg     <= '0;
            stable_cnt_reg <= '0;
            tmo_cnt_reg    <= '0;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            status         <= ST_OK;
            pll_reset      <= 1'b0;
            md_opc         <= OP_NOP;
            md_wdi         <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        ch_reg    <= req_ch;
                        div_reg   <= req_div;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        state_reg <= S_ADDR;
                        // An invalid channel rides through ADDR with no MD op
                        if (req_ch_ok) begin
                            md_opc <= OP_ADDR;
                            md_wdi <= req_addr;
                        end
                    end
                end
                S_ADDR: begin
                    if (!ch_ok) begin
                        status    <= ST_BADCH;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        md_opc    <= OP_WR;
                        md_wdi    <= div_reg;
                        state_reg <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (VERIFY) begin
                        md_opc    <= OP_ADDR;
                        md_wdi    <= tgt_addr;
                        state_reg <= S_VADDR;
                    end else begin
                        md_opc      <= OP_NOP;
                        pll_reset   <= 1'b1;
                        rst_cnt_reg <= '0;
                        state_reg   <= S_PRST;
                    end
                end
                S_VADDR: begin
                    md_opc    <= OP_RD;
                    state_reg <= S_READ;
                end
                S_READ: begin
                    md_opc     <= OP_NOP;
                    rd_cnt_reg <= '0;
                    state_reg  <= S_RWAIT;
                end
                S_RWAIT: begin
                    // Capture read data exactly RD_LAT cycles after the read op
                    if (rd_cnt_reg == RD_LAST) begin
                        rd_data_reg <= md_rdo;
                        state_reg   <= S_CHECK;
                    end else begin
                        rd_cnt_reg <= rd_cnt_reg + 1'b1;
                    end
                end
                S_CHECK: begin
                    // Mismatch leaves the PLL running on its old configuration
                    if (rd_data_reg != div_reg) begin
                        status    <= ST_VFAIL;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        pll_reset   <= 1'b1;
                        rst_cnt_reg <= '0;
                        state_reg   <= S_PRST;
                    end
                end
                S_PRST: begin
                    if (rst_cnt_reg == RST_LAST) begin
                        pll_reset      <= 1'b0;
                        stable_cnt_reg <= '0;
                        tmo_cnt_reg    <= '0;
                        state_reg      <= S_WAIT_LOCK;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    stable_cnt_reg <= stable_next;
                    tmo_cnt_reg    <= tmo_next;
                    // Stability takes priority over a simultaneous timeout
                    if (stable_next == STABLE_TGT) begin
                        status    <= ST_OK;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (tmo_next == TMO_TGT) begin
                        status    <= ST_TMO;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
